// File: rtl/gbc_lcd_capture_sync.sv
// Captures the Game Boy Color LCD pixel stream (async DCLK/CLS/SPS) into VRAM write strobes.
// Latency: SYNC_STAGES+1 cycles from an LCD pin edge to event detection, +1 registered cycle to write/pulse.
// Backpressure: none; the LCD cannot be stalled, so excess pixels set o_overflow and are dropped.
// Ports: i_clk/i_rst (sync, active-high); i_gbcDCLK/CLS/SPS/PixelData async LCD inputs; i_enable
//        capture enable; o_vram* registered write port; o_frameDone/o_frameErr 1-cycle pulses;
//        o_frameBank bank being written; o_overflow sticky until reset.
module gbc_lcd_capture_sync #(
  parameter int H_PIXELS    = 160,
  parameter int V_PIXELS    = 144,
  parameter int PIX_IN_W    = 3,
  parameter int ADDR_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DOUBLE_BUF  = 1,
  parameter int COLOR_MODE  = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_gbcDCLK,
  input  logic                i_gbcCLS,
  input  logic                i_gbcSPS,
  input  logic [PIX_IN_W-1:0] i_gbcPixelData,
  input  logic                i_enable,
  output logic [ADDR_W-1:0]   o_vramWriteAddr,
  output logic [7:0]          o_vramDataOut,
  output logic                o_vramWriteEn,
  output logic                o_frameDone,
  output logic                o_frameBank,
  output logic                o_frameErr,
  output logic                o_overflow
);

  localparam int FRAME_PIX = H_PIXELS * V_PIXELS;
  localparam int HW = $clog2(H_PIXELS + 1);
  localparam int VW = $clog2(V_PIXELS + 1);
  localparam logic [HW-1:0] H_MAX = HW'(H_PIXELS);
  localparam logic [VW-1:0] V_MAX = VW'(V_PIXELS);

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;

  // Synchronisers plus one extra register for falling-edge detection
  logic [SYNC_STAGES-1:0] dclk_sync, cls_sync, sps_sync;
  logic [PIX_IN_W-1:0]    pix_sync [SYNC_STAGES];
  logic                   dclk_d, cls_d, sps_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dclk_sync <= '0;
      cls_sync  <= '0;
      sps_sync  <= '0;
      for (int k = 0; k < SYNC_STAGES; k++) pix_sync[k] <= '0;
      dclk_d    <= 1'b0;
      cls_d     <= 1'b0;
      sps_d     <= 1'b0;
    end else begin
      dclk_sync   <= {dclk_sync[SYNC_STAGES-2:0], i_gbcDCLK};
      cls_sync    <= {cls_sync[SYNC_STAGES-2:0], i_gbcCLS};
      sps_sync    <= {sps_sync[SYNC_STAGES-2:0], i_gbcSPS};
      pix_sync[0] <= i_gbcPixelData;
      for (int k = 1; k < SYNC_STAGES; k++) pix_sync[k] <= pix_sync[k-1];
      dclk_d      <= dclk_sync[SYNC_STAGES-1];
      cls_d       <= cls_sync[SYNC_STAGES-1];
      sps_d       <= sps_sync[SYNC_STAGES-1];
    end
  end

  logic dclk_fall, cls_fall, frame_ev, line_ev, pix_ev;
  assign dclk_fall = dclk_d & ~dclk_sync[SYNC_STAGES-1];
  assign cls_fall  = cls_d  & ~cls_sync[SYNC_STAGES-1];
  assign frame_ev  = sps_d  & ~sps_sync[SYNC_STAGES-1];
  // Lower-priority events coinciding with a higher one are discarded
  assign line_ev   = cls_fall  & ~frame_ev;
  assign pix_ev    = dclk_fall & ~frame_ev & ~cls_fall;

  // Pixel data taken from the same stage as DCLK so it is stable at the detected edge
  logic [PIX_IN_W-1:0] pix_cur;
  logic [7:0]          color;
  assign pix_cur = pix_sync[SYNC_STAGES-1];

  generate
    if (COLOR_MODE == 1) begin : g_grey
      assign color = {4{pix_cur[1], pix_cur[0]}};
    end else if (PIX_IN_W >= 3) begin : g_rgb
      assign color = {{3{pix_cur[0]}}, {3{pix_cur[1]}}, {2{pix_cur[2]}}};
    end else begin : g_rgb_narrow
      assign color = {{3{pix_cur[0]}}, {3{pix_cur[1]}}, 2'b00};
    end
  endgenerate

  state_t          state, state_nxt;
  logic [HW-1:0]   h, h_nxt;
  logic [VW-1:0]   v, v_nxt;
  logic            bank_nxt, ovf_nxt, we_nxt, done_nxt, err_nxt;
  logic [ADDR_W-1:0] addr_cur;

  assign addr_cur = (o_frameBank ? ADDR_W'(FRAME_PIX) : '0)
                  + ADDR_W'(v) * ADDR_W'(H_PIXELS) + ADDR_W'(h);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    h_nxt     = h;
    v_nxt     = v;
    bank_nxt  = o_frameBank;
    ovf_nxt   = o_overflow;
    we_nxt    = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (!i_enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (frame_ev) begin
            state_nxt = ACTIVE;
            h_nxt     = '0;
            v_nxt     = '0;
          end
        end
        ACTIVE: begin
          if (frame_ev) begin
            h_nxt = '0;
            v_nxt = '0;
            if (v == V_MAX) begin
              done_nxt = 1'b1;
              if (DOUBLE_BUF != 0) bank_nxt = ~o_frameBank;
            end else begin
              err_nxt = 1'b1;
            end
          end else if (line_ev) begin
            // CLS with no pixels since the last line is treated as a glitch
            if (h != '0) begin
              h_nxt = '0;
              if (v != V_MAX) v_nxt = v + 1'b1;
            end
          end else if (pix_ev) begin
            if (h < H_MAX && v < V_MAX) begin
              we_nxt = 1'b1;
              h_nxt  = h + 1'b1;
            end else begin
              ovf_nxt   = 1'b1;
              state_nxt = DROP;
            end
          end
        end
        DROP: begin
          // Pixels were lost, so the frame closing here is always reported as bad
          if (frame_ev) begin
            err_nxt   = 1'b1;
            h_nxt     = '0;
            v_nxt     = '0;
            state_nxt = ACTIVE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h               <= '0;
      v               <= '0;
      o_vramWriteAddr <= '0;
      o_vramDataOut   <= '0;
      o_vramWriteEn   <= 1'b0;
      o_frameDone     <= 1'b0;
      o_frameErr      <= 1'b0;
      o_frameBank     <= 1'b0;
      o_overflow      <= 1'b0;
    end else begin
      h             <= h_nxt;
      v             <= v_nxt;
      o_vramWriteEn <= we_nxt;
      o_frameDone   <= done_nxt;
      o_frameErr    <= err_nxt;
      o_frameBank   <= bank_nxt;
      o_overflow    <= ovf_nxt;
      if (we_nxt) begin
        o_vramWriteAddr <= addr_cur;
        o_vramDataOut   <= color;
      end
    end
  end

endmodule
